// File: rtl/spi_rdid_capture_pkg.sv
// Shared definitions for the SPI flash RDID capture block.
// Holds the RDID opcode, the JEDEC ID field widths, the default expected ID,
// the capture FSM state encoding and a small helper for width sizing.
package spi_rdid_capture_pkg;

    localparam logic [7:0] RDID_OPCODE = 8'h9F;

    // JEDEC ID layout: manufacturer, memory type, capacity (MSB first on MISO)
    localparam int MFR_W  = 8;
    localparam int TYPE_W = 8;
    localparam int CAP_W  = 8;
    localparam int ID_W   = MFR_W + TYPE_W + CAP_W;

    localparam logic [ID_W-1:0] DEFAULT_EXPECTED_ID = 24'h20BA18;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_DATA    = 3'd2,
        ST_DONE    = 3'd3,
        ST_WAIT_CS = 3'd4
    } rdid_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_rdid_capture_if.sv
// SPI flash bus as seen by the RDID monitor.
// Signals: spi_sclk (SPI clock), spi_cs_n (chip select, active low),
//          spi_miso (flash data out).
// master: the side driving the bus (SPI master + flash data).
// slave : a passive observer such as spi_rdid_capture.
interface spi_rdid_capture_if;

    logic spi_sclk;
    logic spi_cs_n;
    logic spi_miso;

    modport master (output spi_sclk, output spi_cs_n, output spi_miso);
    modport slave  (input  spi_sclk, input  spi_cs_n, input  spi_miso);

endinterface

// File: rtl/spi_rdid_capture_sync_edge_detect.sv
// Multi-flop synchronizer with rise/fall pulse detection.
// Ports: clk, reset_n (async active-low), din (asynchronous input),
//        level (synchronized level), rise/fall (one-clk edge pulses).
// RESET_VAL is the idle level of the line; all flops reset to it.
module spi_rdid_capture_sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    // Marks when sync_q and prev_q hold real samples rather than reset
    // values, so a line already at its active level when reset is released
    // does not produce a spurious edge.
    logic [SYNC_STAGES:0]   primed_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= {SYNC_STAGES{RESET_VAL}};
            prev_q   <= RESET_VAL;
            primed_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q   <= sync_q[SYNC_STAGES-1];
            primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = primed_q[SYNC_STAGES] &  level & ~prev_q;
    assign fall  = primed_q[SYNC_STAGES] & ~level &  prev_q;

endmodule

// File: rtl/spi_rdid_capture.sv
// Passive SPI flash RDID (0x9F) monitor.
// Skips the instruction phase, captures the DATA_BITS-bit JEDEC ID from MISO
// (MSB first, sampled on SCLK rising edges) and compares it to EXPECTED_ID.
// Ports: clk, reset_n (async active-low), bus (SPI bus, slave modport),
//        id_data (last captured ID), id_valid (one-clk capture pulse),
//        id_match (id_data == EXPECTED_ID, cleared at frame start),
//        frame_error (one-clk pulse on early chip-select release),
//        busy (registered state != IDLE).
module spi_rdid_capture
    import spi_rdid_capture_pkg::*;
#(
    parameter int                   CMD_BITS    = 8,
    parameter int                   DATA_BITS   = ID_W,
    parameter logic [DATA_BITS-1:0] EXPECTED_ID = DEFAULT_EXPECTED_ID,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    spi_rdid_capture_if.slave    bus,
    output logic [DATA_BITS-1:0] id_data,
    output logic                 id_valid,
    output logic                 id_match,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(max2(CMD_BITS, DATA_BITS) + 1);

    logic sclk_level_unused, sclk_rise, sclk_fall_unused;
    logic cs_level_unused, cs_rise, cs_fall;
    logic miso_s, miso_rise_unused, miso_fall_unused;

    // Equal-depth synchronizers keep MISO aligned with the SCLK edge
    spi_rdid_capture_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .din(bus.spi_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    spi_rdid_capture_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .din(bus.spi_cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_rdid_capture_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_miso (
        .clk(clk), .reset_n(reset_n), .din(bus.spi_miso),
        .level(miso_s), .rise(miso_rise_unused), .fall(miso_fall_unused)
    );

    rdid_state_t          state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            id_data     <= '0;
            id_valid    <= 1'b0;
            id_match    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            id_valid    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state     <= ST_CMD;
                        bit_cnt   <= '0;
                        id_match  <= 1'b0;
                        shift_reg <= '0;
                    end
                end

                // cs_rise is tested first so a coincident SCLK edge is not counted
                ST_CMD: begin
                    if (cs_rise) begin
                        frame_error <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (sclk_rise) begin
                        if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= ST_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_DATA: begin
                    if (cs_rise) begin
                        frame_error <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[DATA_BITS-2:0], miso_s};
                        if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= ST_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                // A chip-select release landing exactly here would otherwise be
                // missed by WAIT_CS and stall the monitor until the next frame.
                ST_DONE: begin
                    id_data  <= shift_reg;
                    id_valid <= 1'b1;
                    id_match <= (shift_reg == EXPECTED_ID);
                    state    <= cs_rise ? ST_IDLE : ST_WAIT_CS;
                end

                ST_WAIT_CS: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
